regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Arbitrates two requesters (Req0, Req1) onto the shared 64 x 16 RegisterFile and sequences a clear-on-reset pass that zeroes every register before normal access begins. Port A of the register file carries the single write or one read per cycle. Port B carries a second concurrent read. Sits between the game/control logic and RegisterFile; requesters never drive RegisterFile directly.

## Interface
- AddrWidth, 6, register address width (RegisterFile depth = 2**AddrWidth)
- DataWidth, 16, register data width
- ClearOnReset, 1, 1 = run zeroing pass after reset; 0 = go straight to RUN
- Clock  input  1  system clock, all state on posedge
- Reset  input  1  synchronous, active-high
- ReqN (N=0,1)  input  1  access request, held until granted
- WriteN  input  1  1 = write, 0 = read; qualified by ReqN
- AddrN  input  AddrWidth  register address
- WDataN  input  DataWidth  write data
- GntN  output  1  combinational grant; transfer occurs on posedge where ReqN && GntN
- RValidN  output  1  registered; high one cycle after a granted read
- RDataN  output  DataWidth  registered read data, valid while RValidN
- Busy  output  1  high while clear pass in progress
- RfAddressA  output  AddrWidth  to RegisterFile AddressA
- RfWriteData  output  DataWidth  to RegisterFile WriteData
- RfWriteEnable  output  1  to RegisterFile WriteEnable
- RfAddressB  output  AddrWidth  to RegisterFile AddressB
- RfReadDataA / RfReadDataB  input  DataWidth  from RegisterFile, combinational in address

## Operation
- States: INIT (clear pass), RUN. Reset forces INIT with ClearCount=0 when ClearOnReset=1, else RUN.
- INIT: RfAddressA=ClearCount, RfWriteData=0, RfWriteEnable=1, Gnt0=Gnt1=0, Busy=1; ClearCount increments each cycle; after writing address 2**AddrWidth-1 -> RUN.
- RUN, arbitration per cycle by request type:
  - none: no grants, RfWriteEnable=0.
  - single request: granted; port A used.
  - read + read: both granted; winner per round-robin pointer on port A, other on port B.
  - write + read: both granted; write on port A, read on port B.
  - write + write: one granted per round-robin pointer; loser waits with ReqN held.
- Round-robin pointer (Last): records last requester granted port A in a contested cycle; next contest favours the other one. Reset value favours Req0. Uncontested grants do not move the pointer.
- Read data: RDataN <= granted port's RfReadData; RValidN <= 1 for that cycle only.
- Read-before-write: a read and a write to the same address in the same cycle return the OLD value; the new value is visible from the next cycle.
- Ungranted write data never reaches RfWriteData with RfWriteEnable=1.

## Timing
- Reset values: Gnt0=Gnt1=0, RValid0=RValid1=0, RData0=RData1=0, RfWriteEnable=0, RfAddressA=RfAddressB=0, RfWriteData=0, Busy=1 if ClearOnReset else 0, Last=1 (Req0 favoured).
- Clear pass: exactly 2**AddrWidth cycles (64 default) after Reset deasserts; Busy falls the cycle RUN is entered; first grant possible that cycle.
- Grant latency: 0 cycles (combinational) in RUN when uncontested; write loser granted next cycle if it holds ReqN.
- Read latency: 1 cycle from granted edge to RValidN/RDataN.
- Write latency: data stored on granted edge; readable from next cycle.
- Reset mid-INIT or mid-RUN: grants drop immediately (combinational on Reset), pending RValid cleared, clear pass restarts at address 0.
- ReqN while Busy: held off, no grant, no RValid.

## Test plan
- Reset with ClearOnReset=1 after preloading addr 0x3F=0xFFFF -> Busy high 64 cycles, then read 0x3F returns 0x0000.
- Req0 write 0x0002 to 0x01, next cycle Req0 read 0x01 -> Gnt0 same cycle, RValid0 one cycle later with RData0=0x0002.
- Req0 and Req1 simultaneous reads of 0x01 and 0x02 (holding 0x0002/0x0003) -> both granted same cycle, RData0=0x0002, RData1=0x0003 next cycle.
- Both write continuously (0x0004 to 0x05, 0xF5F5 to 0x06) -> grants alternate Req0, Req1, Req0...; final reads return 0x0004 and 0xF5F5.
- Req0 writes 0x0008 to 0x01 while Req1 reads 0x01 (holding 0x0002) -> both granted, RData1=0x0002; following read returns 0x0008.
- Reset asserted at clear count 20 -> grants 0, RValid 0, clear restarts at address 0, Busy stays high a full 64 cycles.

Source files
------------

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Shares one dual-port 64x16 register file between two requesters (Req0/Req1).
// Port A carries either the single write or one read per cycle; port B carries
// a second concurrent read. After reset an optional clear pass writes zero to
// every register (Busy high) before any request is granted.
//
// Ports
//   clk_i            system clock, all state on posedge
//   rst_i            synchronous active-high reset (also gates grants
//                    combinationally)
//   reqN_i           access request, held by the requester until granted
//   writeN_i         1 = write, 0 = read (qualified by reqN_i)
//   addrN_i          register address
//   wdataN_i         write data
//   gntN_o           combinational grant; transfer on posedge with reqN_i
//   rvalidN_o        registered, high one cycle after a granted read
//   rdataN_o         registered read data, valid while rvalidN_o
//   busy_o           high while the clear pass is running
//   rf_addr_a_o      register file AddressA
//   rf_wdata_o       register file WriteData
//   rf_we_o          register file WriteEnable
//   rf_addr_b_o      register file AddressB
//   rf_rdata_a_i/b_i register file read data (combinational in address)
// -----------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int AddrWidth    = 6,
  parameter int DataWidth    = 16,
  parameter bit ClearOnReset = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_i,
  input  logic                 write0_i,
  input  logic [AddrWidth-1:0] addr0_i,
  input  logic [DataWidth-1:0] wdata0_i,
  input  logic                 req1_i,
  input  logic                 write1_i,
  input  logic [AddrWidth-1:0] addr1_i,
  input  logic [DataWidth-1:0] wdata1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 rvalid0_o,
  output logic [DataWidth-1:0] rdata0_o,
  output logic                 rvalid1_o,
  output logic [DataWidth-1:0] rdata1_o,
  output logic                 busy_o,
  output logic [AddrWidth-1:0] rf_addr_a_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic [AddrWidth-1:0] rf_addr_b_o,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e                RstState = ClearOnReset ? ST_INIT : ST_RUN;
  localparam logic [AddrWidth-1:0]  LastAddr = {AddrWidth{1'b1}};
  localparam logic [AddrWidth-1:0]  AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   clear_cnt_q, clear_cnt_d;
  // last_q = requester (0/1) that last won port A in a contested cycle;
  // the next contest favours the other one, so 1 means Req0 is favoured.
  logic                   last_q, last_d;
  logic                   rvalid0_q, rvalid0_d;
  logic                   rvalid1_q, rvalid1_d;
  logic [DataWidth-1:0]   rdata0_q, rdata0_d;
  logic [DataWidth-1:0]   rdata1_q, rdata1_d;

  // Arbitration results for the current cycle.
  logic                   gnt0;
  logic                   gnt1;
  logic                   a_owner1;   // port A belongs to Req1 (else Req0)
  logic                   b_used;     // second read placed on port B
  logic                   contest;    // same-type request pair, moves pointer
  logic                   busy;
  logic [AddrWidth-1:0]   rf_addr_a;
  logic [DataWidth-1:0]   rf_wdata;
  logic                   rf_we;
  logic [AddrWidth-1:0]   rf_addr_b;

  // State register: FSM state and clear-pass address counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RstState;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  // Next-state logic: walk every address once, then stay in RUN.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    case (state_q)
      ST_INIT: begin
        clear_cnt_d = clear_cnt_q + AddrOne;
        if (clear_cnt_q == LastAddr) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        state_d     = ST_RUN;
        clear_cnt_d = '0;
      end
      default: begin
        state_d     = RstState;
        clear_cnt_d = '0;
      end
    endcase
  end

  // Output logic: grants, port assignment and register file drive.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    a_owner1  = 1'b0;
    b_used    = 1'b0;
    contest   = 1'b0;
    busy      = 1'b0;
    rf_addr_a = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    rf_addr_b = '0;
    if (rst_i) begin
      // Grants drop immediately while reset is held.
      busy = ClearOnReset;
    end else begin
      case (state_q)
        ST_INIT: begin
          busy      = 1'b1;
          rf_addr_a = clear_cnt_q;
          rf_we     = 1'b1;
        end
        ST_RUN: begin
          if (req0_i && req1_i) begin
            if (write0_i && write1_i) begin
              // Only one write port: favoured requester wins, other waits.
              contest  = 1'b1;
              a_owner1 = ~last_q;
              gnt0     = last_q;
              gnt1     = ~last_q;
            end else if (!write0_i && !write1_i) begin
              // Two reads: favoured one on port A, the other on port B.
              contest  = 1'b1;
              a_owner1 = ~last_q;
              gnt0     = 1'b1;
              gnt1     = 1'b1;
              b_used   = 1'b1;
            end else begin
              // Write + read: write always takes port A, no contest.
              a_owner1 = write1_i;
              gnt0     = 1'b1;
              gnt1     = 1'b1;
              b_used   = 1'b1;
            end
          end else if (req0_i) begin
            gnt0 = 1'b1;
          end else if (req1_i) begin
            gnt1     = 1'b1;
            a_owner1 = 1'b1;
          end else begin
            gnt0 = 1'b0;
          end

          // The port A owner is always granted whenever anything is, so
          // write data only reaches the register file for a granted write.
          if (gnt0 || gnt1) begin
            if (a_owner1) begin
              rf_addr_a = addr1_i;
              if (write1_i) begin
                rf_we    = 1'b1;
                rf_wdata = wdata1_i;
              end else begin
                rf_we = 1'b0;
              end
            end else begin
              rf_addr_a = addr0_i;
              if (write0_i) begin
                rf_we    = 1'b1;
                rf_wdata = wdata0_i;
              end else begin
                rf_we = 1'b0;
              end
            end
          end else begin
            rf_we = 1'b0;
          end

          if (b_used) begin
            rf_addr_b = a_owner1 ? addr0_i : addr1_i;
          end else begin
            rf_addr_b = '0;
          end
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
  end

  // Next read-response and pointer values. Read data is taken from the
  // port the requester was placed on; a same-cycle write to that address
  // lands on the clock edge, so the old value is returned.
  always_comb begin
    rvalid0_d = gnt0 & ~write0_i;
    rvalid1_d = gnt1 & ~write1_i;
    if (rvalid0_d) begin
      rdata0_d = a_owner1 ? rf_rdata_b_i : rf_rdata_a_i;
    end else begin
      rdata0_d = rdata0_q;
    end
    if (rvalid1_d) begin
      rdata1_d = a_owner1 ? rf_rdata_a_i : rf_rdata_b_i;
    end else begin
      rdata1_d = rdata1_q;
    end
    if (contest) begin
      last_d = a_owner1;
    end else begin
      last_d = last_q;
    end
  end

  // Read-response and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      last_q    <= 1'b1;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      last_q    <= last_d;
    end
  end

  assign gnt0_o      = gnt0;
  assign gnt1_o      = gnt1;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = busy;
  assign rf_addr_a_o = rf_addr_a;
  assign rf_wdata_o  = rf_wdata;
  assign rf_we_o     = rf_we;
  assign rf_addr_b_o = rf_addr_b;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Bench for regfile_arbiter with a behavioural register file attached to the
// RF ports. A requester-level model (pending requests, favoured requester,
// expected memory image) predicts grants and read data; read responses are
// queued and checked by an independent monitor when rvalid appears.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, write0, req1, write1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rf_addr_a, rf_addr_b;
  logic [DW-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;
  logic          rf_we;

  always #5 clk = ~clk;

  regfile_arbiter #(.AddrWidth(AW), .DataWidth(DW), .ClearOnReset(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .write0_i(write0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .write1_i(write1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .busy_o(busy),
    .rf_addr_a_o(rf_addr_a), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we),
    .rf_addr_b_o(rf_addr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b)
  );

  // Behavioural register file: combinational reads, write on posedge.
  logic [DW-1:0] rf_mem [DEPTH];
  logic          pre_en;
  always_ff @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_mem[i] <= (i == DEPTH - 1) ? 16'hFFFF : (16'hA500 | 16'(i));
      end
    end else if (rf_we) begin
      rf_mem[rf_addr_a] <= rf_wdata;
    end
  end
  assign rf_rdata_a = rf_mem[rf_addr_a];
  assign rf_rdata_b = rf_mem[rf_addr_b];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  bit            p_req [2];
  bit            p_wr  [2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_data[2];
  int            fav;                 // requester favoured in next contest
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] q0_data[$], q1_data[$];
  int            q0_due[$],  q1_due[$];

  task automatic model_reset();
    fav = 0;
    for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    q0_data.delete(); q1_data.delete(); q0_due.delete(); q1_due.delete();
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_req[i]  = 1'b1;
    p_wr[i]   = w;
    p_addr[i] = a;
    p_data[i] = d;
  endtask

  // One RUN cycle: drive pending requests, predict and check grants and
  // port A write traffic, queue expected read data, update memory image.
  task automatic do_cycle();
    bit g [2];
    int wi;
    req0   = p_req[0];
    write0 = p_req[0] ? p_wr[0]   : 1'($urandom);
    addr0  = p_req[0] ? p_addr[0] : AW'($urandom);
    wdata0 = p_req[0] ? p_data[0] : DW'($urandom);
    req1   = p_req[1];
    write1 = p_req[1] ? p_wr[1]   : 1'($urandom);
    addr1  = p_req[1] ? p_addr[1] : AW'($urandom);
    wdata1 = p_req[1] ? p_data[1] : DW'($urandom);
    #1;
    g[0] = 1'b0; g[1] = 1'b0;
    if (p_req[0] && p_req[1]) begin
      if (p_wr[0] && p_wr[1]) begin
        g[fav] = 1'b1;
        fav = 1 - fav;
      end else if (!p_wr[0] && !p_wr[1]) begin
        g[0] = 1'b1; g[1] = 1'b1;
        fav = 1 - fav;
      end else begin
        g[0] = 1'b1; g[1] = 1'b1;
      end
    end else begin
      g[0] = p_req[0];
      g[1] = p_req[1];
    end
    chk("busy_run", 32'(busy), 32'd0);
    chk("gnt0", 32'(gnt0), 32'(g[0]));
    chk("gnt1", 32'(gnt1), 32'(g[1]));
    wi = -1;
    for (int i = 0; i < 2; i++) if (g[i] && p_wr[i]) wi = i;
    chk("rf_we", 32'(rf_we), (wi >= 0) ? 32'd1 : 32'd0);
    if (wi >= 0) begin
      chk("rf_wdata", 32'(rf_wdata), 32'(p_data[wi]));
      chk("rf_addr_a_wr", 32'(rf_addr_a), 32'(p_addr[wi]));
    end
    if (g[0] && !p_wr[0]) begin q0_data.push_back(exp_mem[p_addr[0]]); q0_due.push_back(cyc + 1); end
    if (g[1] && !p_wr[1]) begin q1_data.push_back(exp_mem[p_addr[1]]); q1_due.push_back(cyc + 1); end
    if (wi >= 0) exp_mem[p_addr[wi]] = p_data[wi];
    for (int i = 0; i < 2; i++) if (g[i]) p_req[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) do_cycle();
  endtask

  // Counts Busy cycles after reset release while both requesters hold reads;
  // checks the clear traffic and that nothing is granted until RUN.
  task automatic wait_clear(input string tag);
    int n = 0;
    req0 = 1'b1; write0 = 1'b0; addr0 = 6'h3F;
    req1 = 1'b1; write1 = 1'b0; addr1 = 6'h01;
    #1;
    while (busy && n < 200) begin
      if (gnt0 || gnt1) chk({tag, "_gnt_busy"}, {30'd0, gnt1, gnt0}, 32'd0);
      if (rf_addr_a !== 6'(n) || rf_we !== 1'b1 || rf_wdata !== 16'h0000)
        chk({tag, "_clear_wr"}, {9'd0, rf_we, rf_addr_a, rf_wdata}, {9'd0, 1'b1, 6'(n), 16'h0000});
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_clear_cycles"}, 32'(n), 32'd64);
    chk({tag, "_gnt_run_entry"}, {30'd0, gnt1, gnt0}, 32'd3);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Monitor: every rvalid must match the oldest queued read for that side.
  initial begin
    logic [DW-1:0] d;
    int            due;
    forever begin
      @(negedge clk);
      if (rvalid0) begin
        if (q0_data.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else begin
          d = q0_data.pop_front(); due = q0_due.pop_front();
          chk("rdata0", 32'(rdata0), 32'(d));
          chk("rvalid0_latency", 32'(cyc), 32'(due));
        end
      end
      if (rvalid1) begin
        if (q1_data.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else begin
          d = q1_data.pop_front(); due = q1_due.pop_front();
          chk("rdata1", 32'(rdata1), 32'(d));
          chk("rvalid1_latency", 32'(cyc), 32'(due));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pre_en = 1'b1;
    req0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1; pre_en = 1'b0;
    @(posedge clk); #1;
    // Reset values while reset is held.
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst_rdata", {rdata1, rdata0}, 32'd0);
    chk("rst_rf", {9'd0, rf_we, rf_addr_a, rf_wdata}, 32'd0);
    chk("rst_rf_addr_b", 32'(rf_addr_b), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    wait_clear("boot");
    model_reset();

    // Preloaded 0x3F must read back as zero after the clear pass.
    set_req(0, 1'b0, 6'h3F, '0); do_cycle();
    // Write then read on Req0.
    set_req(0, 1'b1, 6'h01, 16'h0002); do_cycle();
    set_req(0, 1'b0, 6'h01, '0); do_cycle();
    set_req(1, 1'b1, 6'h02, 16'h0003); do_cycle();
    // Concurrent reads.
    set_req(0, 1'b0, 6'h01, '0); set_req(1, 1'b0, 6'h02, '0); do_cycle();
    drain(2);
    // Continuous write/write contention: grants alternate.
    for (int k = 0; k < 6; k++) begin
      if (!p_req[0]) set_req(0, 1'b1, 6'h05, 16'h0004);
      if (!p_req[1]) set_req(1, 1'b1, 6'h06, 16'hF5F5);
      do_cycle();
    end
    for (int k = 0; k < 4 && (p_req[0] || p_req[1]); k++) do_cycle();
    set_req(0, 1'b0, 6'h05, '0); set_req(1, 1'b0, 6'h06, '0); do_cycle();
    // Write and read to the same address: old value returned, new one next.
    set_req(0, 1'b1, 6'h01, 16'h0008); set_req(1, 1'b0, 6'h01, '0); do_cycle();
    set_req(1, 1'b0, 6'h01, '0); do_cycle();
    drain(2);

    // Randomized traffic, narrow address range to force collisions.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_req[i] && $urandom_range(9) < 6) begin
          set_req(i, 1'($urandom),
                  ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7)),
                  DW'($urandom));
        end
      end
      do_cycle();
    end
    for (int k = 0; k < 4 && (p_req[0] || p_req[1]); k++) do_cycle();
    drain(2);
    chk("queues_empty_run", 32'(q0_data.size() + q1_data.size()), 32'd0);

    // Reset in the middle of the clear pass restarts it from address 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_clear_addr", 32'(rf_addr_a), 32'd20);
    chk("mid_clear_busy", 32'(busy), 32'd1);
    req0 = 1'b1; write0 = 1'b0; addr0 = 6'h02;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    rst = 1'b0;
    wait_clear("reclear");
    model_reset();
    // Everything written before is gone again.
    set_req(0, 1'b0, 6'h05, '0); set_req(1, 1'b0, 6'h06, '0); do_cycle();
    set_req(0, 1'b0, 6'h01, '0); do_cycle();
    drain(3);
    chk("queues_empty_end", 32'(q0_data.size() + q1_data.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
